// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: CPU and loader/DMA share one single-port memory.
// Each grant gives one registered memory cycle followed by a one-cycle ack to the winner.
module dmem_arbiter #(
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [15:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic        c_ack,
    output logic [15:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic [15:0] dmemaddr,
    output logic [15:0] dmemwdata,
    output logic        dmemwrite,
    output logic        dmemread,
    input  logic [15:0] dmemrdata
);

    localparam bit CpuWins = (CPU_PRIORITY != 0);

    typedef enum logic [1:0] {StIdle, StServeC, StServeD} state_e;

    state_e      state_q, state_d;
    logic        last_d_q;
    logic        we_q;
    logic [15:0] addr_q, wdata_q;
    logic        c_ack_q, d_ack_q;
    logic [15:0] c_rdata_q, d_rdata_q;

    logic c_elig, d_elig, grant_c, grant_d;

    // A requester is masked during its own ack cycle so a held req counts as a new request.
    assign c_elig  = c_req & ~c_ack_q;
    assign d_elig  = d_req & ~d_ack_q;
    assign grant_c = (state_q == StIdle) & c_elig & (~d_elig | CpuWins | last_d_q);
    assign grant_d = (state_q == StIdle) & d_elig & ~grant_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant_c) begin
                    state_d = StServeC;
                end else if (grant_d) begin
                    state_d = StServeD;
                end
            end
            StServeC, StServeD: state_d = StIdle;
            default:            state_d = StIdle;
        endcase
    end

    always_comb begin
        dmemaddr  = 16'h0000;
        dmemwdata = 16'h0000;
        dmemwrite = 1'b0;
        dmemread  = 1'b0;
        case (state_q)
            StServeC, StServeD: begin
                dmemaddr  = addr_q;
                dmemwdata = wdata_q;
                dmemwrite = we_q;
                dmemread  = ~we_q;
            end
            default: ;
        endcase
    end

    // Grant-time capture of the winner's request, plus completion bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_d_q  <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            c_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            if (grant_c) begin
                we_q     <= c_we;
                addr_q   <= c_addr;
                wdata_q  <= c_wdata;
                last_d_q <= 1'b0;
            end else if (grant_d) begin
                we_q     <= d_we;
                addr_q   <= d_addr;
                wdata_q  <= d_wdata;
                last_d_q <= 1'b1;
            end
            c_ack_q <= (state_q == StServeC);
            d_ack_q <= (state_q == StServeD);
            if ((state_q == StServeC) && !we_q) begin
                c_rdata_q <= dmemrdata;
            end
            if ((state_q == StServeD) && !we_q) begin
                d_rdata_q <= dmemrdata;
            end
        end
    end

    assign c_ack   = c_ack_q;
    assign d_ack   = d_ack_q;
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance with a memory model, plus a
// CPU-priority instance used to compare tie-break decisions.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [15:0] c_addr, c_wdata, d_addr, d_wdata;

    logic        c_ack, d_ack, dmemwrite, dmemread;
    logic [15:0] c_rdata, d_rdata, dmemaddr, dmemwdata, dmemrdata;

    logic        p_c_ack, p_d_ack, p_dmemwrite, p_dmemread;
    logic [15:0] p_c_rdata, p_d_rdata, p_dmemaddr, p_dmemwdata, p_dmemrdata;

    logic [15:0] mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.CPU_PRIORITY(0)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .dmemaddr(dmemaddr), .dmemwdata(dmemwdata), .dmemwrite(dmemwrite),
        .dmemread(dmemread), .dmemrdata(dmemrdata)
    );

    dmem_arbiter #(.CPU_PRIORITY(1)) dut_prio (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(p_c_ack), .c_rdata(p_c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(p_d_ack), .d_rdata(p_d_rdata),
        .dmemaddr(p_dmemaddr), .dmemwdata(p_dmemwdata), .dmemwrite(p_dmemwrite),
        .dmemread(p_dmemread), .dmemrdata(p_dmemrdata)
    );

    // Only the round-robin instance writes the memory; the priority instance just reads it.
    assign dmemrdata   = mem[dmemaddr[7:0]];
    assign p_dmemrdata = mem[p_dmemaddr[7:0]];

    always @(posedge clock) begin
        if (dmemwrite) mem[dmemaddr[7:0]] = dmemwdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h20] = 16'h5A5A;
        mem[8'h30] = 16'h3030;
        mem[8'h08] = 16'h0808;

        reset = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0; c_wdata = 16'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        tick();
        check("rst_c_ack", c_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_dmemaddr", dmemaddr, 0);
        check("rst_dmemwrite", dmemwrite, 0);

        // Request pending while reset is high must not be granted.
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        tick();
        check("rst_no_grant", dmemread, 0);
        reset = 1'b0;

        // CPU read alone.
        tick();
        check("c_rd_read", dmemread, 1);
        check("c_rd_write", dmemwrite, 0);
        check("c_rd_addr", dmemaddr, 16'h0010);
        tick();
        check("c_rd_ack", c_ack, 1);
        check("c_rd_data", c_rdata, 16'hBEEF);
        check("c_rd_d_ack", d_ack, 0);
        c_req = 1'b0;
        tick();
        check("c_rd_idle", dmemread, 0);
        check("c_rd_ack_low", c_ack, 0);

        // Loader write alone, then CPU reads it back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0004; d_wdata = 16'h1234;
        tick();
        check("d_wr_write", dmemwrite, 1);
        check("d_wr_read", dmemread, 0);
        check("d_wr_addr", dmemaddr, 16'h0004);
        check("d_wr_wdata", dmemwdata, 16'h1234);
        tick();
        check("d_wr_ack", d_ack, 1);
        check("d_wr_c_ack", c_ack, 0);
        check("d_wr_rdata_hold", d_rdata, 0);
        d_req = 1'b0; d_we = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0004;
        tick();
        check("rb_addr", dmemaddr, 16'h0004);
        tick();
        check("rb_ack", c_ack, 1);
        check("rb_data", c_rdata, 16'h1234);
        c_req = 1'b0;
        tick();

        // Address change after grant must not affect the access.
        c_req = 1'b1; c_addr = 16'h0020;
        tick();
        c_addr = 16'h0030;
        #1;
        check("latch_addr", dmemaddr, 16'h0020);
        tick();
        check("latch_data", c_rdata, 16'h5A5A);
        c_req = 1'b0;
        tick();

        // CPU write: rdata holds, memory updated.
        c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0040; c_wdata = 16'hCAFE;
        tick();
        check("c_wr_write", dmemwrite, 1);
        check("c_wr_wdata", dmemwdata, 16'hCAFE);
        tick();
        check("c_wr_ack", c_ack, 1);
        check("c_wr_rdata_hold", c_rdata, 16'h5A5A);
        check("c_wr_mem", mem[8'h40], 16'hCAFE);
        c_req = 1'b0; c_we = 1'b0;
        tick();

        // Both requesting continuously after reset: C, D, C, D.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c_req = 1'b1; c_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0004;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("rr_c_ack%0d", i), c_ack, (i % 4 == 2));
            check($sformatf("rr_d_ack%0d", i), d_ack, (i % 4 == 0));
            check($sformatf("rr_addr%0d", i), dmemaddr,
                  (i % 4 == 1) ? 16'h0010 : (i % 4 == 3) ? 16'h0004 : 16'h0000);
            check($sformatf("pr_c_ack%0d", i), p_c_ack, (i % 4 == 2));
            check($sformatf("pr_d_ack%0d", i), p_d_ack, (i % 4 == 0));
        end
        check("rr_d_data", d_rdata, 16'h1234);
        check("rr_c_data", c_rdata, 16'hBEEF);

        // CPU served alone, then a fresh tie: round-robin picks D, priority picks C.
        d_req = 1'b0;
        tick();
        check("solo_c_addr", dmemaddr, 16'h0010);
        tick();
        c_req = 1'b0;
        tick();
        c_req = 1'b1; d_req = 1'b1;
        tick();
        check("tie_rr_addr", dmemaddr, 16'h0004);
        check("tie_pr_addr", p_dmemaddr, 16'h0010);
        c_req = 1'b0; d_req = 1'b0;
        tick();
        check("tie_rr_d_ack", d_ack, 1);
        check("tie_pr_c_ack", p_c_ack, 1);
        check("tie_rr_c_ack", c_ack, 0);
        tick();
        check("drop_not_served", dmemread, 0);
        check("drop_no_ack", c_ack, 0);

        // Reset in the middle of a loader write.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0008; d_wdata = 16'hFFFF;
        tick();
        check("mid_wr_write", dmemwrite, 1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_wr_drop", dmemwrite, 0);
        check("mid_wr_addr", dmemaddr, 0);
        tick();
        check("mid_wr_mem", mem[8'h08], 16'h0808);
        check("mid_wr_no_ack", d_ack, 0);
        check("mid_wr_d_rdata", d_rdata, 0);
        d_req = 1'b0; d_we = 1'b0;
        reset = 1'b0;
        tick();
        check("mid_wr_no_ack2", d_ack, 0);
        check("mid_wr_c_rdata", c_rdata, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: CPU_PRIORITY, default 0; 0 = round-robin arbitration, 1 = CPU always wins simultaneous requests.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 c_req  input  1  CPU access request, held until c_ack.
REQ-006 c_we  input  1  CPU write (1) or read (0), valid with c_req.
REQ-007 c_addr  input  16  CPU word address.
REQ-008 c_wdata  input  16  CPU write data.
REQ-009 c_ack  output  1  one-cycle completion pulse to the CPU.
REQ-010 c_rdata  output  16  registered read data for the CPU.
REQ-011 d_req, d_we, d_addr[15:0], d_wdata[15:0]  input  1/1/16/16  loader/DMA requester, same semantics as the c_ signals.
REQ-012 d_ack  output  1; d_rdata  output  16; loader completion pulse and read data.
REQ-013 dmemaddr  output  16  address to data memory.
REQ-014 dmemwdata  output  16  write data to data memory.
REQ-015 dmemwrite  output  1  memory write enable; the memory writes on the rising edge.
REQ-016 dmemread  output  1  memory read enable.
REQ-017 dmemrdata  input  16  combinational read data from memory.

Function
REQ-018 FSM states: IDLE, SERVE_C, SERVE_D; encoding is implementer's choice.
REQ-019 IDLE: at each edge, the eligible request set is {c_req & ~c_ack, d_req & ~d_ack}; the acked requester is masked for exactly the cycle its ack is high.
REQ-020 IDLE with one eligible request: go to SERVE_x for that requester; with none: stay IDLE.
REQ-021 Both eligible, CPU_PRIORITY=1: CPU wins.
REQ-022 Both eligible, CPU_PRIORITY=0: the requester not served last wins, and the last-served flag updates on every grant.
REQ-023 On the grant edge, latch the winner's addr, wdata and we into internal registers; later changes on that requester's inputs do not affect the access.
REQ-024 In SERVE_x, dmemaddr and dmemwdata come from the latched values, with dmemwrite = latched we and dmemread = ~latched we.
REQ-025 In IDLE: dmemwrite = 0, dmemread = 0, dmemaddr = 0, dmemwdata = 0.
REQ-026 SERVE_x always returns to IDLE at the next edge, giving exactly one memory cycle per grant.
REQ-027 Read completion: at the SERVE_x exit edge, x_rdata <= dmemrdata.
REQ-028 Write completion: x_rdata holds its previous value.
REQ-029 x_ack is high for exactly the one cycle after SERVE_x; no other ack condition exists.
REQ-030 Latency: a request seen in IDLE at edge N gets its memory cycle in N+1 and its ack in N+2; sustained throughput is one access per 2 cycles.
REQ-031 c_ack and d_ack are never high in the same cycle.
REQ-032 dmemwrite and dmemread are never both high.
REQ-033 A requester that drops req before being granted is not served; no latched request survives a return to IDLE.
REQ-034 A requester that keeps req high through its ack cycle is treated as a new request and becomes eligible again the cycle after the ack.

Reset
REQ-035 While reset is high: state = IDLE, c_ack = d_ack = 0, c_rdata = d_rdata = 0, all memory outputs 0, last-served = loader (so the CPU wins the first tie).
REQ-036 Asserting reset during SERVE_x drops dmemwrite and dmemread immediately (asynchronously), and no ack is issued for the aborted access.
REQ-037 After reset deasserts, the first grant occurs no earlier than the first rising edge with reset low.

Verification
REQ-038 CPU read alone: memory[0x0010]=0xBEEF, c_req=1, c_we=0, c_addr=0x0010 -> dmemread=1 with dmemaddr=0x0010 in cycle 1, c_ack=1 and c_rdata=0xBEEF in cycle 2, d_ack stays 0.
REQ-039 Loader write alone: d_req=1, d_we=1, d_addr=0x0004, d_wdata=0x1234 -> one cycle with dmemwrite=1, then d_ack; a following CPU read of 0x0004 returns 0x1234.
REQ-040 Round-robin with CPU_PRIORITY=0, both requesting continuously after reset -> grant order C, D, C, D, with acks in cycles 2, 4, 6, 8; neither requester is served twice in a row.
REQ-041 CPU_PRIORITY=1, both requesting continuously -> every grant goes to the CPU while c_req re-asserts; the loader is served only in IDLE cycles where c_req is low or masked by c_ack.
REQ-042 Reset mid-write: reset asserted during SERVE_D with d_we=1, d_addr=0x0008 -> dmemwrite falls before the next edge, memory[0x0008] is unchanged, and no d_ack is issued.
REQ-043 Input change after grant: c_addr changes from 0x0020 to 0x0030 in the SERVE_C cycle -> dmemaddr stays 0x0020.
